// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: address/instruction words and the
// {pc, inst} record that travels from the fetch queue to decode.
package fetch_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    localparam inst_t INST_NOP = 32'h0000_0013;

    // Clears the byte-offset bits without a part-select, so every input bit is consumed.
    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} records.
// Flush empties the queue and overrides any push or pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [2];

    // The upstream issue check keeps push from landing in a full queue;
    // pop is only asserted while the queue is non-empty.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, drives the sync-read instruction ROM, tags in-flight
// requests and buffers returned words for decode over a valid/ready handshake.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter int    QDEPTH   = 2
) (
    input  logic  CLK,
    input  logic  RST_N,
    output addr_t imem_addr,
    input  inst_t imem_rdata,
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    output logic  out_valid,
    input  logic  out_ready,
    output addr_t out_pc,
    output inst_t out_inst
);

    localparam logic [2:0] QDEPTH_L = 3'(QDEPTH);

    addr_t        pc_q, pc_d;
    logic         f2_valid_q, f2_valid_d;
    addr_t        f2_pc_q, f2_pc_d;

    logic         redirect;
    addr_t        target;
    logic         pop;
    logic         issue;
    logic [2:0]   occ;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t q_push_data;

    assign redirect = redirect_valid & RST_N;
    assign target   = word_align(redirect_pc);

    assign out_valid = (q_count != 2'd0) & ~redirect & RST_N;
    assign pop       = out_valid & out_ready;

    // Only issue when a queue slot is guaranteed to be free by the time the word returns.
    assign occ   = {1'b0, q_count} + {2'b00, f2_valid_q};
    assign issue = (occ - {2'b00, pop}) < QDEPTH_L;

    assign imem_addr = redirect ? target : pc_q;

    always_comb begin
        pc_d       = pc_q;
        f2_valid_d = issue;
        f2_pc_d    = f2_pc_q;
        if (redirect) begin
            f2_valid_d = 1'b1;
            f2_pc_d    = target;
            pc_d       = target + 32'd4;
        end else if (issue) begin
            f2_pc_d = pc_q;
            pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q       <= RESET_PC;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
        end
    end

    // A redirect flushes the queue, which also drops the word returning this cycle.
    assign q_push_data = '{pc: f2_pc_q, inst: imem_rdata};

    fetch_queue u_queue (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .flush_i     (redirect),
        .push_i      (f2_valid_q),
        .push_data_i (q_push_data),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    assign out_pc   = q_head.pc;
    assign out_inst = q_head.inst;

endmodule
